// File: rtl/prng_errpos.sv
// Error-position generator for the Niederreiter encryption path: steps an external PRNG,
// keeps in-range, non-duplicate candidates and streams ERR_T distinct positions downstream.
module prng_errpos #(
    parameter int PRNG_DAT_W = 25,
    parameter int POS_W      = 11,
    parameter int N_LEN      = 2048,
    parameter int ERR_T      = 27
) (
    input  logic                          clk,
    input  logic                          rst_b,
    input  logic                          start,
    input  logic                          seed_ld,
    input  logic [PRNG_DAT_W-1:0]         seed_dat,
    output logic [1:0]                    prng_typ_sel,
    output logic                          prng_t_sel,
    output logic [PRNG_DAT_W-1:0]         prng_t_dat,
    input  logic [PRNG_DAT_W-1:0]         prng_r_dat,
    output logic                          pos_vld,
    input  logic                          pos_rdy,
    output logic [POS_W-1:0]              pos_dat,
    output logic [$clog2(ERR_T+1)-1:0]    pos_idx,
    output logic                          busy,
    output logic                          done
);

    localparam int IDX_W = $clog2(ERR_T + 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SEED   = 3'd1;
    localparam logic [2:0] ST_REQ    = 3'd2;
    localparam logic [2:0] ST_SAMPLE = 3'd3;
    localparam logic [2:0] ST_CHECK  = 3'd4;
    localparam logic [2:0] ST_EMIT   = 3'd5;
    localparam logic [2:0] ST_FIN    = 3'd6;

    localparam logic [1:0] TYP_HALT = 2'd0;
    localparam logic [1:0] TYP_STEP = 2'd1;
    localparam logic [1:0] TYP_LOAD = 2'd2;

    // One extra bit so N_LEN = 2^POS_W is representable.
    localparam logic [POS_W:0]   N_LEN_V  = (POS_W + 1)'(N_LEN);
    localparam logic [IDX_W-1:0] ERR_T_V  = IDX_W'(ERR_T);

    logic [2:0]            state_q, state_d;
    logic [PRNG_DAT_W-1:0] seed_q, seed_d;
    logic [POS_W-1:0]      cand_q, cand_d;
    logic [POS_W-1:0]      pos_dat_q, pos_dat_d;
    logic                  pos_vld_q, pos_vld_d;
    logic [IDX_W-1:0]      pos_idx_q, pos_idx_d;
    logic [POS_W-1:0]      tbl_q [ERR_T];
    logic [POS_W-1:0]      tbl_d [ERR_T];

    logic                  cand_dup;
    logic                  cand_oor;
    logic [IDX_W-1:0]      pos_idx_inc;
    logic                  prng_lsb_unused;

    assign prng_lsb_unused = ^prng_r_dat[PRNG_DAT_W-POS_W-1:0];

    // Only the first pos_idx entries belong to the current run.
    always_comb begin
        cand_dup = 1'b0;
        for (int i = 0; i < ERR_T; i++) begin
            if ((IDX_W'(i) < pos_idx_q) && (tbl_q[i] == cand_q)) begin
                cand_dup = 1'b1;
            end
        end
    end

    assign cand_oor    = {1'b0, cand_q} >= N_LEN_V;
    assign pos_idx_inc = pos_idx_q + IDX_W'(1);

    // NOTE: every variable gets a default at the top of the block, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        seed_d    = seed_q;
        cand_d    = cand_q;
        pos_dat_d = pos_dat_q;
        pos_vld_d = pos_vld_q;
        pos_idx_d = pos_idx_q;
        tbl_d     = tbl_q;

        case (state_q)
            ST_IDLE: begin
                if (seed_ld) begin
                    seed_d  = seed_dat;
                    state_d = ST_SEED;
                end else if (start) begin
                    for (int i = 0; i < ERR_T; i++) begin
                        tbl_d[i] = '0;
                    end
                    pos_idx_d = '0;
                    state_d   = ST_REQ;
                end
            end
            ST_SEED: begin
                state_d = ST_IDLE;
            end
            ST_REQ: begin
                state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                cand_d  = prng_r_dat[PRNG_DAT_W-1 -: POS_W];
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (cand_oor || cand_dup) begin
                    state_d = ST_REQ;
                end else begin
                    for (int i = 0; i < ERR_T; i++) begin
                        if (IDX_W'(i) == pos_idx_q) begin
                            tbl_d[i] = cand_q;
                        end
                    end
                    pos_dat_d = cand_q;
                    pos_vld_d = 1'b1;
                    state_d   = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (pos_rdy) begin
                    pos_vld_d = 1'b0;
                    pos_idx_d = pos_idx_inc;
                    state_d   = (pos_idx_inc == ERR_T_V) ? ST_FIN : ST_REQ;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values together.
    // NOTE: the position table is plain flops, not RAM, so it is cleared on reset like any register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= ST_IDLE;
            seed_q    <= '0;
            cand_q    <= '0;
            pos_dat_q <= '0;
            pos_vld_q <= 1'b0;
            pos_idx_q <= '0;
            for (int i = 0; i < ERR_T; i++) begin
                tbl_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            seed_q    <= seed_d;
            cand_q    <= cand_d;
            pos_dat_q <= pos_dat_d;
            pos_vld_q <= pos_vld_d;
            pos_idx_q <= pos_idx_d;
            tbl_q     <= tbl_d;
        end
    end

    // PRNG controls decode straight from state, so reset forces halt without waiting for an edge.
    always_comb begin
        prng_typ_sel = TYP_HALT;
        if (state_q == ST_SEED) begin
            prng_typ_sel = TYP_LOAD;
        end else if (state_q == ST_REQ) begin
            prng_typ_sel = TYP_STEP;
        end
    end

    assign prng_t_sel = (state_q == ST_SEED);
    assign prng_t_dat = prng_t_sel ? seed_q : '0;
    assign pos_vld    = pos_vld_q;
    assign pos_dat    = pos_dat_q;
    assign pos_idx    = pos_idx_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_FIN);

endmodule

// File: tb/tb_prng_errpos.sv
// Bench for prng_errpos: a word-list PRNG stub feeds the DUT; a list-filtering model predicts
// the accepted positions, rejection count and cycle timing of each run.
module tb_prng_errpos;

    localparam int DW   = 25;
    localparam int PW   = 11;
    localparam int NL   = 2000;
    localparam int ET   = 3;
    localparam int IW   = $clog2(ET + 1);
    localparam int MAXW = 4096;

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic          start = 1'b0;
    logic          seed_ld = 1'b0;
    logic [DW-1:0] seed_dat = '0;
    logic [1:0]    prng_typ_sel;
    logic          prng_t_sel;
    logic [DW-1:0] prng_t_dat;
    logic [DW-1:0] prng_r_dat = '0;
    logic          pos_vld;
    logic          pos_rdy = 1'b0;
    logic [PW-1:0] pos_dat;
    logic [IW-1:0] pos_idx;
    logic          busy;
    logic          done;

    logic [DW-1:0] words [MAXW];
    int            step_cnt = 0;
    int            cyc = 0;
    int            n_chk = 0;
    int            n_pass = 0;

    prng_errpos #(
        .PRNG_DAT_W (DW),
        .POS_W      (PW),
        .N_LEN      (NL),
        .ERR_T      (ET)
    ) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .start        (start),
        .seed_ld      (seed_ld),
        .seed_dat     (seed_dat),
        .prng_typ_sel (prng_typ_sel),
        .prng_t_sel   (prng_t_sel),
        .prng_t_dat   (prng_t_dat),
        .prng_r_dat   (prng_r_dat),
        .pos_vld      (pos_vld),
        .pos_rdy      (pos_rdy),
        .pos_dat      (pos_dat),
        .pos_idx      (pos_idx),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // PRNG stub: each step presents the next word of the list; a load presents the seed.
    always @(posedge clk) begin
        if (prng_typ_sel == 2'd1) begin
            prng_r_dat <= words[step_cnt % MAXW];
            step_cnt   <= step_cnt + 1;
        end else if (prng_typ_sel == 2'd2) begin
            prng_r_dat <= prng_t_dat;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic set_word(input int off, input int c);
        words[(step_cnt + off) % MAXW] = {PW'(c), (DW - PW)'($urandom)};
    endtask

    task automatic run_case(input string tag, input int stall_pct, input int hold_first);
        int   exp_pos[$];
        int   got[$];
        int   rej = 0;
        int   rej_first = 0;
        int   s0, c0, k, c;
        int   first_vld = -1;
        int   done_cyc = -1;
        int   idx_at_done = -1;
        int   stalls = 0;
        int   hold_err = 0;
        bit   dup;
        logic prev_hold = 1'b0;
        logic [PW-1:0] prev_dat = '0;

        s0 = step_cnt;
        c0 = 0;
        k  = s0;
        while (exp_pos.size() < ET && k < s0 + 1000) begin
            c = int'(words[k % MAXW][DW-1 -: PW]);
            k++;
            dup = 1'b0;
            foreach (exp_pos[j]) if (exp_pos[j] == c) dup = 1'b1;
            if (c >= NL || dup) rej++;
            else begin
                if (exp_pos.size() == 0) rej_first = rej;
                exp_pos.push_back(c);
            end
        end

        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            start = (n == 0);
            if (n == 0) c0 = cyc;
            pos_rdy = ($urandom_range(99) >= stall_pct) && !(pos_vld && stalls < hold_first);
            @(negedge clk);
            if (prev_hold && (!pos_vld || pos_dat != prev_dat)) hold_err++;
            if (pos_vld && prng_typ_sel != 2'd0) hold_err++;
            if (pos_vld && first_vld < 0) first_vld = cyc;
            if (pos_vld && pos_rdy) got.push_back(int'(pos_dat));
            if (pos_vld && !pos_rdy) stalls++;
            prev_hold = pos_vld && !pos_rdy;
            prev_dat  = pos_dat;
            if (done) begin
                done_cyc    = cyc;
                idx_at_done = int'(pos_idx);
                break;
            end
        end
        start = 1'b0;

        if (done_cyc < 0) begin
            check({tag, " timeout"}, 0, 1);
            return;
        end
        check({tag, " first_vld_cycle"}, first_vld - c0, 4 + 3 * rej_first);
        for (int i = 0; i < ET; i++) begin
            check($sformatf("%s pos[%0d]", tag, i), (i < got.size()) ? got[i] : -1, exp_pos[i]);
        end
        check({tag, " n_emitted"}, got.size(), ET);
        check({tag, " done_cycle"}, done_cyc - c0, 4 * ET + 1 + 3 * rej + stalls);
        check({tag, " pos_idx_at_done"}, idx_at_done, ET);
        check({tag, " prng_steps"}, step_cnt - s0, ET + rej);
        check({tag, " hold_violations"}, hold_err, 0);

        @(posedge clk);
        #1;
        pos_rdy = 1'b0;
        @(negedge clk);
        check({tag, " busy_after"}, int'(busy), 0);
        check({tag, " pos_idx_kept"}, int'(pos_idx), ET);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int  c;
        bit  reached;

        for (int i = 0; i < MAXW; i++) begin
            case ($urandom_range(2))
                0:       c = $urandom_range(2047, NL);
                1:       c = $urandom_range(7);
                default: c = $urandom_range(NL - 1);
            endcase
            words[i] = {PW'(c), (DW - PW)'($urandom)};
        end

        // Reset state
        #1;
        check("rst typ_sel", int'(prng_typ_sel), 0);
        check("rst t_sel", int'(prng_t_sel), 0);
        check("rst t_dat", int'(prng_t_dat), 0);
        check("rst pos_vld", int'(pos_vld), 0);
        check("rst pos_dat", int'(pos_dat), 0);
        check("rst pos_idx", int'(pos_idx), 0);
        check("rst busy", int'(busy), 0);
        check("rst done", int'(done), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_b = 1'b1;

        // Seed load, with a coincident start that must be dropped
        @(posedge clk);
        #1;
        seed_ld  = 1'b1;
        seed_dat = DW'(100);
        start    = 1'b1;
        @(posedge clk);
        #1;
        seed_ld  = 1'b0;
        start    = 1'b0;
        @(negedge clk);
        check("seed typ_sel", int'(prng_typ_sel), 2);
        check("seed t_sel", int'(prng_t_sel), 1);
        check("seed t_dat", int'(prng_t_dat), 100);
        check("seed busy", int'(busy), 1);
        @(negedge clk);
        check("seed_after typ_sel", int'(prng_typ_sel), 0);
        check("seed_after t_sel", int'(prng_t_sel), 0);
        check("seed_after t_dat", int'(prng_t_dat), 0);
        check("seed_after busy", int'(busy), 0);
        @(negedge clk);
        check("seed start_dropped busy", int'(busy), 0);

        // Basic run, including the largest legal position
        set_word(0, 5);
        set_word(1, 900);
        set_word(2, NL - 1);
        run_case("basic", 0, 0);

        // Out-of-range rejects, including the N_LEN boundary itself
        set_word(0, 2047);
        set_word(1, 10);
        set_word(2, NL);
        set_word(3, 11);
        set_word(4, NL - 1);
        run_case("range", 0, 0);

        // Duplicate rejects
        set_word(0, 5);
        set_word(1, 5);
        set_word(2, 6);
        set_word(3, 5);
        set_word(4, 6);
        set_word(5, 7);
        run_case("dup", 0, 0);

        // Backpressure on the first position
        run_case("backpressure", 0, 5);

        // Randomized runs with random backpressure
        for (int r = 0; r < 8; r++) begin
            run_case($sformatf("rand%0d", r), 30, 0);
        end

        // Reset in EMIT with pos_idx=1
        set_word(0, 40);
        set_word(1, 41);
        set_word(2, 42);
        @(posedge clk);
        #1;
        pos_rdy = 1'b1;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        reached = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (pos_vld && pos_idx == IW'(1)) begin
                reached = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            pos_rdy = (pos_idx == '0);
        end
        check("midrst reached_emit_idx1", int'(reached), 1);
        #2;
        rst_b = 1'b0;
        #1;
        check("midrst typ_sel", int'(prng_typ_sel), 0);
        check("midrst t_sel", int'(prng_t_sel), 0);
        check("midrst t_dat", int'(prng_t_dat), 0);
        check("midrst pos_vld", int'(pos_vld), 0);
        check("midrst pos_dat", int'(pos_dat), 0);
        check("midrst pos_idx", int'(pos_idx), 0);
        check("midrst busy", int'(busy), 0);
        check("midrst done", int'(done), 0);
        pos_rdy = 1'b0;
        @(posedge clk);
        #1;
        rst_b = 1'b1;

        // Fresh run reusing the aborted run's positions
        set_word(0, 40);
        set_word(1, 40);
        set_word(2, 41);
        set_word(3, 42);
        run_case("after_rst", 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
